// File: rtl/xs3_pkg.sv
// Shared types and constants for the serial excess-3 decoder.
package xs3_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_t;

    localparam logic [3:0] XS3_OFFSET = 4'd3;
    localparam logic [3:0] XS3_MIN    = 4'h3;
    localparam logic [3:0] XS3_MAX    = 4'hC;

    // Number of serial bits in one frame of nDigits excess-3 digits.
    function automatic int frameLen(input int nDigits);
        return 4 * nDigits;
    endfunction

endpackage

// File: rtl/xs3_digit_decode.sv
// Combinational decode of one excess-3 code into a BCD digit plus an invalid-code flag.
module xs3_digit_decode
    import xs3_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [3:0] bcd_o,
    output logic       err_o
);

    // Codes 3..C map to 0..9; the six unused codes decode to zero and raise the flag.
    always_comb begin
        bcd_o = 4'h0;
        err_o = 1'b1;
        if ((code_i >= XS3_MIN) && (code_i <= XS3_MAX)) begin
            bcd_o = code_i - XS3_OFFSET;
            err_o = 1'b0;
        end
    end

endmodule

// File: rtl/xs3_serial_decoder.sv
// Bit-serial excess-3 to packed BCD decoder with a valid/ready output handshake.
module xs3_serial_decoder
    import xs3_pkg::*;
#(
    parameter int NDIGITS = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ser_in,
    input  logic                   ser_valid,
    output logic                   ser_ready,
    input  logic                   sync,
    output logic [4*NDIGITS-1:0]   bcd_out,
    output logic [NDIGITS-1:0]     digit_err,
    output logic                   code_err,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int FRAME_BITS = frameLen(NDIGITS);
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    state_t                  state_q;
    logic [CNT_W-1:0]        bitCnt_q;
    logic [FRAME_BITS-1:0]   shiftReg_q;
    logic [FRAME_BITS-1:0]   shiftReg_d;
    logic                    serReady_q;
    logic                    outValid_q;
    logic [4*NDIGITS-1:0]    bcd_q;
    logic [NDIGITS-1:0]      digitErr_q;
    logic                    codeErr_q;
    logic [4*NDIGITS-1:0]    decBcd;
    logic [NDIGITS-1:0]      decErr;

    // Bits arrive LSB first, digit 0 first, so shifting right leaves the first bit at position 0.
    assign shiftReg_d = {ser_in, shiftReg_q[FRAME_BITS-1:1]};

    // Decode the word as it will look once the incoming bit is shifted in, so the last bit's edge captures a complete frame.
    for (genvar g = 0; g < NDIGITS; g++) begin : g_digit
        xs3_digit_decode u_decode (
            .code_i (shiftReg_d[4*g +: 4]),
            .bcd_o  (decBcd[4*g +: 4]),
            .err_o  (decErr[g])
        );
    end

    // Frame FSM: collect bits, capture decoded results on the last bit, then hold until downstream takes them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bitCnt_q   <= '0;
            shiftReg_q <= '0;
            serReady_q <= 1'b1;
            outValid_q <= 1'b0;
            bcd_q      <= '0;
            digitErr_q <= '0;
            codeErr_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, SHIFT: begin
                    if (sync) begin
                        state_q    <= IDLE;
                        bitCnt_q   <= '0;
                        shiftReg_q <= '0;
                    end else if (ser_valid) begin
                        shiftReg_q <= shiftReg_d;
                        if (bitCnt_q == LAST_BIT) begin
                            state_q    <= HOLD;
                            bitCnt_q   <= '0;
                            serReady_q <= 1'b0;
                            outValid_q <= 1'b1;
                            bcd_q      <= decBcd;
                            digitErr_q <= decErr;
                            codeErr_q  <= |decErr;
                        end else begin
                            state_q  <= SHIFT;
                            bitCnt_q <= bitCnt_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_q    <= IDLE;
                        serReady_q <= 1'b1;
                        outValid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ser_ready = serReady_q;
    assign out_valid = outValid_q;
    assign bcd_out   = bcd_q;
    assign digit_err = digitErr_q;
    assign code_err  = codeErr_q;

endmodule

// File: tb/tb_xs3_serial_decoder.sv
// Self-checking bench for xs3_serial_decoder (NDIGITS=2) against a behavioural decode model.
module tb_xs3_serial_decoder;

    localparam int ND = 2;
    localparam int FB = 4 * ND;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ser_in = 1'b0;
    logic            ser_valid = 1'b0;
    logic            ser_ready;
    logic            sync = 1'b0;
    logic [FB-1:0]   bcd_out;
    logic [ND-1:0]   digit_err;
    logic            code_err;
    logic            out_valid;
    logic            out_ready = 1'b0;

    int errCount   = 0;
    int checkCount = 0;

    xs3_serial_decoder #(.NDIGITS(ND)) dut (
        .clk       (clk),
        .rst       (rst),
        .ser_in    (ser_in),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .sync      (sync),
        .bcd_out   (bcd_out),
        .digit_err (digit_err),
        .code_err  (code_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Watchdog so the run can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference decode: each nibble is an excess-3 code; 3..12 decodes to value-3, anything else is an error digit of 0.
    function automatic void modelDecode(input logic [FB-1:0] frame,
                                        output logic [FB-1:0] bcd,
                                        output logic [ND-1:0] err);
        bcd = '0;
        err = '0;
        for (int k = 0; k < ND; k++) begin
            int c;
            c = int'(frame[4*k +: 4]);
            if (c >= 3 && c <= 12) begin
                bcd[4*k +: 4] = 4'(c - 3);
            end else begin
                err[k] = 1'b1;
            end
        end
    endfunction

    // Drive one clock's worth of inputs; called at a falling edge, returns at the next falling edge.
    task automatic applyStimulus(input logic v, input logic b, input logic s, input logic r);
        ser_valid = v;
        ser_in    = b;
        sync      = s;
        out_ready = r;
        @(negedge clk);
    endtask

    // Send a frame LSB first, optionally with random idle gaps in front of each bit.
    task automatic sendFrame(input logic [FB-1:0] frame, input bit gaps);
        for (int i = 0; i < FB; i++) begin
            if (gaps) begin
                int n;
                n = int'($urandom_range(0, 3));
                for (int j = 0; j < n; j++) applyStimulus(1'b0, 1'($urandom), 1'b0, 1'b0);
            end
            applyStimulus(1'b1, frame[i], 1'b0, 1'b0);
        end
        ser_valid = 1'b0;
    endtask

    // Check a completed frame against the model.
    task automatic checkFrame(input string tag, input logic [FB-1:0] frame);
        logic [FB-1:0] eb;
        logic [ND-1:0] ee;
        modelDecode(frame, eb, ee);
        checkCount++;
        if (out_valid !== 1'b1) begin
            errCount++;
            $display("[TB] FAIL %s_valid: got %b want 1", tag, out_valid);
        end
        checkCount++;
        if (bcd_out !== eb) begin
            errCount++;
            $display("[TB] FAIL %s_bcd: got %h want %h (frame %h)", tag, bcd_out, eb, frame);
        end
        checkCount++;
        if (digit_err !== ee || code_err !== (|ee)) begin
            errCount++;
            $display("[TB] FAIL %s_err: got %b/%b want %b/%b", tag, digit_err, code_err, ee, |ee);
        end
    endtask

    // Handshake the held frame away (offering a bit that must be ignored) and check the one-cycle HOLD exit.
    task automatic consumeFrame(input string tag, input logic [FB-1:0] heldBcd);
        applyStimulus(1'b1, 1'($urandom), 1'b0, 1'b1);
        out_ready = 1'b0;
        ser_valid = 1'b0;
        checkCount++;
        if (out_valid !== 1'b0 || ser_ready !== 1'b1) begin
            errCount++;
            $display("[TB] FAIL %s_release: got valid=%b ready=%b want valid=0 ready=1", tag, out_valid, ser_ready);
        end
        checkCount++;
        if (bcd_out !== heldBcd) begin
            errCount++;
            $display("[TB] FAIL %s_retain: got %h want %h", tag, bcd_out, heldBcd);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        checkCount++;
        if (ser_ready !== 1'b1 || out_valid !== 1'b0 || bcd_out !== '0 || code_err !== 1'b0 || digit_err !== '0) begin
            errCount++;
            $display("[TB] FAIL reset_values: got ready=%b valid=%b bcd=%h derr=%b cerr=%b want 1 0 00 00 0",
                     ser_ready, out_valid, bcd_out, digit_err, code_err);
        end
        ser_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_valid_frame();
        logic [FB-1:0] frame;
        frame = 8'h8B;
        for (int i = 0; i < FB - 1; i++) applyStimulus(1'b1, frame[i], 1'b0, 1'b0);
        checkCount++;
        if (out_valid !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL early_valid: got %b want 0", out_valid);
        end
        applyStimulus(1'b1, frame[FB-1], 1'b0, 1'b0);
        ser_valid = 1'b0;
        checkFrame("valid", frame);
        checkCount++;
        if (bcd_out !== 8'h58) begin
            errCount++;
            $display("[TB] FAIL valid_literal: got %h want 58", bcd_out);
        end
        consumeFrame("valid", 8'h58);
    endtask

    task automatic test_invalid_code();
        sendFrame(8'h3E, 1'b0);
        checkFrame("invalid", 8'h3E);
        checkCount++;
        if (bcd_out !== 8'h00 || digit_err !== 2'b01 || code_err !== 1'b1) begin
            errCount++;
            $display("[TB] FAIL invalid_literal: got %h/%b/%b want 00/01/1", bcd_out, digit_err, code_err);
        end
        consumeFrame("invalid", 8'h00);
    endtask

    task automatic test_backpressure();
        logic [FB-1:0] f1, f2, eb;
        logic [ND-1:0] ee;
        f1 = 8'h74;
        f2 = 8'($urandom);
        modelDecode(f1, eb, ee);
        sendFrame(f1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'($urandom), 1'b0, 1'b0);
            checkCount++;
            if (ser_ready !== 1'b0 || out_valid !== 1'b1 || bcd_out !== eb || digit_err !== ee) begin
                errCount++;
                $display("[TB] FAIL hold_stable: got ready=%b valid=%b bcd=%h err=%b want 0 1 %h %b",
                         ser_ready, out_valid, bcd_out, digit_err, eb, ee);
            end
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkCount++;
        if (out_valid !== 1'b1 || bcd_out !== eb) begin
            errCount++;
            $display("[TB] FAIL hold_sync: got valid=%b bcd=%h want 1 %h", out_valid, bcd_out, eb);
        end
        consumeFrame("bp", eb);
        sendFrame(f2, 1'b0);
        checkFrame("bp_next", f2);
        modelDecode(f2, eb, ee);
        consumeFrame("bp_next", eb);
    endtask

    task automatic test_sync();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'($urandom), 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        sendFrame(8'h5A, 1'b0);
        checkFrame("sync", 8'h5A);
        checkCount++;
        if (bcd_out !== 8'h27) begin
            errCount++;
            $display("[TB] FAIL sync_literal: got %h want 27", bcd_out);
        end
        consumeFrame("sync", 8'h27);
    endtask

    task automatic test_gaps();
        for (int n = 0; n < 8; n++) begin
            logic [FB-1:0] f, eb;
            logic [ND-1:0] ee;
            f = 8'($urandom);
            modelDecode(f, eb, ee);
            sendFrame(f, 1'b1);
            checkFrame("gaps", f);
            consumeFrame("gaps", eb);
        end
    endtask

    task automatic test_reset_mid();
        logic [FB-1:0] f, eb;
        logic [ND-1:0] ee;
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'($urandom), 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        checkCount++;
        if (ser_ready !== 1'b1 || out_valid !== 1'b0 || bcd_out !== '0) begin
            errCount++;
            $display("[TB] FAIL reset_mid: got ready=%b valid=%b bcd=%h want 1 0 00", ser_ready, out_valid, bcd_out);
        end
        ser_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        f = 8'h96;
        sendFrame(f, 1'b0);
        checkFrame("after_rst", f);
        #2 rst = 1'b1;
        #1;
        checkCount++;
        if (out_valid !== 1'b0 || bcd_out !== '0 || code_err !== 1'b0 || ser_ready !== 1'b1) begin
            errCount++;
            $display("[TB] FAIL reset_hold: got valid=%b bcd=%h cerr=%b ready=%b want 0 00 0 1",
                     out_valid, bcd_out, code_err, ser_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        f = 8'($urandom);
        modelDecode(f, eb, ee);
        sendFrame(f, 1'b1);
        checkFrame("after_rst2", f);
        consumeFrame("after_rst2", eb);
    endtask

    // Scenario sequence and final summary.
    initial begin
        $display("[TB] xs3_serial_decoder bench start");
        test_reset();
        test_valid_frame();
        test_invalid_code();
        test_backpressure();
        test_sync();
        test_gaps();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/xs3_serial_decoder.md
# xs3_serial_decoder

Bit-serial excess-3 to BCD decoder. It is the receive-side counterpart of the team's BCD code converter. It collects NDIGITS excess-3 digits from a 1-bit serial stream, subtracts the offset of 3 from each digit, and presents a packed BCD word on a valid/ready output handshake. Any digit outside the excess-3 code space is flagged. It sits between a serial link front end and downstream display/arithmetic logic.

## Interface
- NDIGITS, default 2: number of digits per frame (1..8).
- clk  input  1: rising-edge clock.
- rst  input  1: asynchronous, active-high reset.
- ser_in  input  1: serial data bit.
- ser_valid  input  1: ser_in is valid this cycle.
- ser_ready  output  1: decoder accepts a bit this cycle.
- sync  input  1: discard any partial frame and restart at bit 0.
- bcd_out  output  4*NDIGITS: decoded word; digit k is at [4k+3:4k].
- digit_err  output  NDIGITS: per-digit invalid-code flag.
- code_err  output  1: OR of digit_err.
- out_valid  output  1: bcd_out, digit_err and code_err are valid.
- out_ready  input  1: downstream consumes the frame.

## Operation
- A bit transfers on any edge where ser_valid && ser_ready.
- Frame order: digit 0 first. Within each digit, LSB first. A frame is 4*NDIGITS bits.
- FSM states:
  - IDLE: ser_ready=1. Goes to SHIFT on the first accepted bit.
  - SHIFT: ser_ready=1. Accepts bits into the shift register and counts them. Goes to HOLD on the last bit.
  - HOLD: ser_ready=0, out_valid=1. Goes to IDLE on out_ready.
- Decode per digit, with c the 4-bit excess-3 code:
  - 4'h3 ≤ c ≤ 4'hC: bcd = c − 3 (4-bit result, no borrow possible), err=0.
  - Otherwise (0,1,2,D,E,F): bcd = 4'h0, err=1.
- Decode results are registered at the transition to HOLD. The outputs are stable for the whole of HOLD.
- An invalid digit does not abort the frame. The frame completes normally with its error flags set.
- sync, in IDLE or SHIFT:
  - Clears the bit counter and the shift register.
  - The state becomes IDLE.
  - A bit offered in the same cycle is discarded. sync has priority over ser_valid.
- sync in HOLD is ignored. The held frame is never lost.
- ser_valid gaps of any length in SHIFT are allowed. The counter holds during a gap.

## Timing
- Reset values: ser_ready=1, out_valid=0, bcd_out=0, digit_err=0, code_err=0, FSM=IDLE, counter=0.
- Latency: out_valid rises on the clock edge that accepts the last bit, so it is visible in the next cycle.
- HOLD with out_ready=1 lasts one cycle. out_valid is then 0 and ser_ready is 1 in the next cycle.
- No bit is accepted in the cycle out_valid drops. The first bit of the next frame is accepted one cycle after the handshake.
- Wrap-around: the counter runs from 0 to 4*NDIGITS−1, then resets to 0 on entry to HOLD.
- Output registers keep their last frame value after HOLD until the next frame completes.
- rst mid-frame or in HOLD: all state and outputs go immediately to reset values. The partial or held frame is dropped.
- No combinational path from ser_in/ser_valid to any output. The only combinational path is out_ready to the FSM next-state logic.

## Structure
- Shared package xs3_pkg:
  - State enum: IDLE, SHIFT, HOLD.
  - Constants: XS3_OFFSET=4'd3, XS3_MIN=4'h3, XS3_MAX=4'hC.
  - Function or constant for the frame length, 4*NDIGITS.
- Sub-module xs3_digit_decode: combinational, 4-bit code in, 4-bit bcd and err out. Instantiated NDIGITS times with generate.
- Top level holds the FSM, the bit counter (width $clog2(4*NDIGITS)), the shift register and the output registers.

## Test plan
- Reset: assert rst mid-cycle (asynchronous) → ser_ready=1, out_valid=0, bcd_out=8'h00, code_err=0.
- Valid frame, NDIGITS=2: send digits 8 (xs3 4'hB) then 5 (xs3 4'h8), LSB first, back-to-back → out_valid one cycle after the 8th bit; bcd_out=8'h58, digit_err=2'b00.
- Invalid code: send digit 0 = 4'hE and digit 1 = 4'h3 → bcd_out=8'h00, digit_err=2'b01, code_err=1.
- Backpressure: complete a frame and hold out_ready=0 for 5 cycles while driving ser_valid=1 → ser_ready=0, no bits accepted, outputs stable; release out_ready → next frame decodes correctly.
- sync mid-frame: send 3 bits, then pulse sync together with ser_valid=1, then send a full frame for 8'h27 → bcd_out=8'h27. The 3 earlier bits and the bit in the sync cycle do not appear.
- Gaps and reset: send bits with random ser_valid gaps → same result as back-to-back; assert rst after 5 bits → state returns to IDLE, and a following full frame decodes correctly.
